// File: rtl/arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester identifiers and the round-robin pick rule.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        CPU = 1'b0,
        DMA = 1'b1
    } req_id_t;

    localparam int WS_WIDTH = 3;

    // A lone request wins outright; on a tie the requester not served last wins.
    function automatic req_id_t pick_requester(input logic    cpu_req,
                                               input logic    dma_req,
                                               input req_id_t last_grant);
        if (cpu_req && dma_req)
            return (last_grant == DMA) ? CPU : DMA;
        else if (cpu_req)
            return CPU;
        else
            return DMA;
    endfunction

endpackage

// File: rtl/ws_counter.sv
// Wait-state down-counter: loads the wait count at grant, counts down while
// the access is in progress and flags zero on the final memory cycle.
module ws_counter
    import arb_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                dec,
    input  logic [WS_WIDTH-1:0] load_val,
    output logic                zero
);

    localparam logic [WS_WIDTH-1:0] WS_ONE = 1;

    logic [WS_WIDTH-1:0] count;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - WS_ONE;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU, DMA) arbiter in front of a single unified memory port with
// round-robin grant, configurable wait states and a one-cycle ack strobe.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_adr,
    input  logic [31:0] dma_wd,
    output logic [31:0] dma_rd,
    output logic        dma_ack,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        busy
);

    localparam logic [WS_WIDTH-1:0] WS_LOAD = WS_WIDTH'(WAIT_STATES);

    arb_state_t state, state_nxt;
    req_id_t    grant, last_grant, pick_id;
    logic       lat_we;
    logic       any_req;
    logic       cnt_load, cnt_dec, cnt_zero;

    assign any_req = cpu_req | dma_req;
    assign pick_id = pick_requester(cpu_req, dma_req, last_grant);

    ws_counter u_ws_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (WS_LOAD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    cnt_load  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    mem_we    = lat_we;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request attributes are captured once at grant; later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant      <= CPU;
            last_grant <= DMA;
            lat_we     <= 1'b0;
            mem_adr    <= '0;
            mem_wd     <= '0;
            cpu_rd     <= '0;
            dma_rd     <= '0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            busy    <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= pick_id;
                        last_grant <= pick_id;
                        if (pick_id == CPU) begin
                            lat_we  <= cpu_we;
                            mem_adr <= cpu_adr;
                            mem_wd  <= cpu_wd;
                        end else begin
                            lat_we  <= dma_we;
                            mem_adr <= dma_adr;
                            mem_wd  <= dma_wd;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_zero) begin
                        if (grant == CPU) begin
                            cpu_ack <= 1'b1;
                            if (!lat_we)
                                cpu_rd <= mem_rd;
                        end else begin
                            dma_ack <= 1'b1;
                            if (!lat_we)
                                dma_rd <= mem_rd;
                        end
                    end
                end
                DONE: begin
                    lat_we  <= 1'b0;
                    mem_adr <= '0;
                    mem_wd  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (WAIT_STATES 0 and 1) share stimulus and are
// compared every cycle against a timestamp-based transaction model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_adr, cpu_wd, dma_adr, dma_wd;
    logic [31:0] mem_rd0, mem_rd1;

    logic [31:0] cpu_rd0, dma_rd0, mem_adr0, mem_wd0;
    logic        cpu_ack0, dma_ack0, mem_we0, busy0;
    logic [31:0] cpu_rd1, dma_rd1, mem_adr1, mem_wd1;
    logic        cpu_ack1, dma_ack1, mem_we1, busy1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd0), .cpu_ack(cpu_ack0),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wd(dma_wd),
        .dma_rd(dma_rd0), .dma_ack(dma_ack0),
        .mem_we(mem_we0), .mem_adr(mem_adr0), .mem_wd(mem_wd0), .mem_rd(mem_rd0),
        .busy(busy0)
    );

    mem_port_arbiter #(.WAIT_STATES(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd1), .cpu_ack(cpu_ack1),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wd(dma_wd),
        .dma_rd(dma_rd1), .dma_ack(dma_ack1),
        .mem_we(mem_we1), .mem_adr(mem_adr1), .mem_wd(mem_wd1), .mem_rd(mem_rd1),
        .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: an access granted at edge g is BUSY for intervals
    // k = 0..ws, acks in interval ws+1 and is idle again from interval ws+2.
    typedef struct {
        bit          active;
        bit          owner;   // 0 = CPU, 1 = DMA
        bit          we;
        bit          last;
        int          g;
        logic [31:0] adr, wd, cpu_rd, dma_rd;
    } mdl_t;

    mdl_t m[2];
    int   n = 0;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.active = 0; r.owner = 0; r.we = 0; r.last = 1; r.g = 0;
        r.adr = '0; r.wd = '0; r.cpu_rd = '0; r.dma_rd = '0;
        return r;
    endfunction

    function automatic mdl_t step(input mdl_t cur, input int ws, input logic [31:0] rd);
        mdl_t r;
        bit   was_idle;
        bit   id;
        if (reset) return mdl_reset();
        r        = cur;
        was_idle = !cur.active;
        if (cur.active && n - cur.g == ws + 1 && !cur.we) begin
            if (cur.owner) r.dma_rd = rd;
            else           r.cpu_rd = rd;
        end
        if (cur.active && n - cur.g == ws + 2) r.active = 0;
        if (was_idle && (cpu_req || dma_req)) begin
            id       = (cpu_req && dma_req) ? !cur.last : dma_req;
            r.active = 1;
            r.g      = n;
            r.owner  = id;
            r.last   = id;
            r.we     = id ? dma_we  : cpu_we;
            r.adr    = id ? dma_adr : cpu_adr;
            r.wd     = id ? dma_wd  : cpu_wd;
        end
        return r;
    endfunction

    // Event log used by the directed scenarios.
    int          ack_cnt[2], we_cnt[2], cpu_ack_cnt[2], rise_cnt[2];
    int          ack_n[2], rise_n[2], we_n[2], last_ack_n[2];
    logic [31:0] we_adr[2], we_wd[2], rise_adr[2];
    bit          prev_busy[2];
    int          ack_q[$];
    int          gap_q[$];

    task automatic compare(input int id, input int ws, input logic busy, input logic cack,
                           input logic dack, input logic we, input logic [31:0] adr,
                           input logic [31:0] wd, input logic [31:0] crd, input logic [31:0] drd);
        mdl_t e;
        int   k;
        e = m[id];
        k = n - e.g;
        check($sformatf("busy[%0d]", id), busy, e.active);
        check($sformatf("cpu_ack[%0d]", id), cack, e.active && k == ws + 1 && !e.owner);
        check($sformatf("dma_ack[%0d]", id), dack, e.active && k == ws + 1 && e.owner);
        check($sformatf("mem_we[%0d]", id), we, e.active && k == ws && e.we);
        check($sformatf("cpu_rd[%0d]", id), crd, e.cpu_rd);
        check($sformatf("dma_rd[%0d]", id), drd, e.dma_rd);
        check($sformatf("ack_excl[%0d]", id), cack & dack, 0);
        if (!e.active) begin
            check($sformatf("mem_adr_idle[%0d]", id), adr, 0);
            check($sformatf("mem_wd_idle[%0d]", id), wd, 0);
        end else if (k <= ws) begin
            check($sformatf("mem_adr[%0d]", id), adr, e.adr);
            check($sformatf("mem_wd[%0d]", id), wd, e.wd);
        end
        if (reset) last_ack_n[id] = -1;
        if (busy && !prev_busy[id]) begin
            rise_cnt[id]++;
            rise_n[id]   = n;
            rise_adr[id] = adr;
            if (id == 1 && last_ack_n[1] >= 0) gap_q.push_back(n - last_ack_n[1]);
        end
        if (cack || dack) begin
            ack_cnt[id]++;
            ack_n[id]      = n;
            last_ack_n[id] = n;
            if (cack) cpu_ack_cnt[id]++;
            if (id == 1) ack_q.push_back(dack ? 1 : 0);
        end
        if (we) begin
            we_cnt[id]++;
            we_n[id]   = n;
            we_adr[id] = adr;
            we_wd[id]  = wd;
        end
        prev_busy[id] = busy;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            n++;
            m[0] = step(m[0], 0, mem_rd0);
            m[1] = step(m[1], 1, mem_rd1);
            #1;
            compare(0, 0, busy0, cpu_ack0, dma_ack0, mem_we0, mem_adr0, mem_wd0, cpu_rd0, dma_rd0);
            compare(1, 1, busy1, cpu_ack1, dma_ack1, mem_we1, mem_adr1, mem_wd1, cpu_rd1, dma_rd1);
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_ack(input string name, input int id, input int base, input int budget);
        int t = 0;
        while (ack_cnt[id] <= base && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, ack_cnt[id] > base, 1);
    endtask

    task automatic wait_rise(input string name, input int id, input int base, input int budget);
        int t = 0;
        while (rise_cnt[id] <= base && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, rise_cnt[id] > base, 1);
    endtask

    initial begin
        int we_s, ack_s, ca_s, t;
        for (int i = 0; i < 2; i++) begin
            m[i] = mdl_reset();
            ack_cnt[i] = 0; we_cnt[i] = 0; cpu_ack_cnt[i] = 0; rise_cnt[i] = 0;
            ack_n[i] = 0; rise_n[i] = 0; we_n[i] = 0; last_ack_n[i] = -1;
            prev_busy[i] = 0;
        end
        reset   = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wd = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_adr = '0; dma_wd = '0;
        mem_rd0 = '0;   mem_rd1 = '0;
        cycles(3);
        check("rst_busy", busy1, 0);
        check("rst_cpu_rd", cpu_rd1, 0);
        check("rst_mem_adr", mem_adr1, 0);
        reset = 1'b0;
        cycles(2);

        // CPU read at 0x10 returning 0xDEADBEEF
        mem_rd0 = 32'hDEADBEEF; mem_rd1 = 32'hDEADBEEF;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h10;
        we_s = we_cnt[1]; ack_s = ack_cnt[1];
        wait_ack("rd_ack_wait", 1, ack_s, 20);
        cpu_req = 1'b0;
        cycles(3);
        check("rd_cpu_rd", cpu_rd1, 32'hDEADBEEF);
        check("rd_cpu_rd_ws0", cpu_rd0, 32'hDEADBEEF);
        check("rd_latency_ws1", ack_n[1] - rise_n[1] + 1, 3);
        check("rd_latency_ws0", ack_n[0] - rise_n[0] + 1, 2);
        check("rd_no_we", we_cnt[1] - we_s, 0);

        // DMA write 0x12345678 to 0x20
        dma_req = 1'b1; dma_we = 1'b1; dma_adr = 32'h20; dma_wd = 32'h12345678;
        we_s = we_cnt[1]; ack_s = ack_cnt[1]; ca_s = cpu_ack_cnt[1];
        wait_ack("wr_ack_wait", 1, ack_s, 20);
        dma_req = 1'b0;
        cycles(3);
        check("wr_we_pulses", we_cnt[1] - we_s, 1);
        check("wr_we_adr", we_adr[1], 32'h20);
        check("wr_we_wd", we_wd[1], 32'h12345678);
        check("wr_ack_after_we", ack_n[1] - we_n[1], 1);
        check("wr_no_cpu_ack", cpu_ack_cnt[1] - ca_s, 0);
        check("wr_cpu_rd_kept", cpu_rd1, 32'hDEADBEEF);

        // Both requesters held high from reset: round-robin with one idle bubble
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h100;
        dma_req = 1'b1; dma_we = 1'b0; dma_adr = 32'h200;
        cycles(2);
        ack_q.delete();
        gap_q.delete();
        reset = 1'b0;
        t = 0;
        while (ack_q.size() < 4 && t < 40) begin
            mem_rd0 = $urandom; mem_rd1 = $urandom;
            @(negedge clk);
            t++;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        cycles(4);
        check("rr_ack_count", ack_q.size() >= 4, 1);
        check("rr_order0", ack_q[0], 0);
        check("rr_order1", ack_q[1], 1);
        check("rr_order2", ack_q[2], 0);
        check("rr_order3", ack_q[3], 1);
        check("rr_gap0", gap_q[0], 2);
        check("rr_gap1", gap_q[1], 2);
        check("rr_gap2", gap_q[2], 2);

        // Request dropped and inputs changed one cycle after grant
        mem_rd0 = 32'h0A0B0C0D; mem_rd1 = 32'h0A0B0C0D;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h40;
        we_s = we_cnt[1]; ca_s = cpu_ack_cnt[1]; t = rise_cnt[1];
        wait_rise("drop_rise_wait", 1, t, 20);
        cpu_req = 1'b0; cpu_adr = 32'h44; cpu_we = 1'b1;
        ack_s = ack_cnt[1];
        wait_ack("drop_ack_wait", 1, ack_s - 1, 20);
        cycles(4);
        check("drop_adr", rise_adr[1], 32'h40);
        check("drop_cpu_ack", cpu_ack_cnt[1] - ca_s, 1);
        check("drop_no_we", we_cnt[1] - we_s, 0);
        check("drop_cpu_rd", cpu_rd1, 32'h0A0B0C0D);

        // Reset during BUSY of a write, then a normal access
        dma_req = 1'b1; dma_we = 1'b1; dma_adr = 32'h80; dma_wd = 32'hCAFEF00D;
        t = rise_cnt[1];
        wait_rise("rst_rise_wait", 1, t, 20);
        reset = 1'b1; dma_req = 1'b0;
        we_s = we_cnt[1]; ack_s = ack_cnt[1];
        cycles(2);
        reset = 1'b0;
        cycles(4);
        check("rst_mid_no_we", we_cnt[1] - we_s, 0);
        check("rst_mid_no_ack", ack_cnt[1] - ack_s, 0);
        check("rst_mid_idle", busy1, 0);
        mem_rd0 = 32'h0BADF00D; mem_rd1 = 32'h0BADF00D;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h30;
        ack_s = ack_cnt[1];
        wait_ack("post_rst_ack_wait", 1, ack_s, 20);
        cpu_req = 1'b0;
        cycles(3);
        check("post_rst_cpu_rd", cpu_rd1, 32'h0BADF00D);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 800; i++) begin
            reset   = ($urandom_range(0, 99) == 0);
            cpu_req = ($urandom_range(0, 3) != 0);
            dma_req = ($urandom_range(0, 2) != 0);
            cpu_we  = $urandom_range(0, 1);
            dma_we  = $urandom_range(0, 1);
            cpu_adr = $urandom; cpu_wd = $urandom;
            dma_adr = $urandom; dma_wd = $urandom;
            mem_rd0 = $urandom; mem_rd1 = $urandom;
            @(negedge clk);
        end
        reset = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        cycles(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1: extra memory cycles per access, legal range 0..7.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cpu_req  input  1  CPU controller access request, held until cpu_ack.
REQ-005 SHALL have ports cpu_we, cpu_adr, cpu_wd  input  1/32/32  CPU write enable, address, write data.
REQ-006 SHALL have ports cpu_rd, cpu_ack  output  32/1  CPU read data and one-cycle completion strobe.
REQ-007 SHALL have ports dma_req, dma_we, dma_adr, dma_wd  input  1/1/32/32  DMA/debug requester, same rules as CPU.
REQ-008 SHALL have ports dma_rd, dma_ack  output  32/1  DMA read data and completion strobe.
REQ-009 SHALL have ports mem_we, mem_adr, mem_wd  output  1/32/32  shared unified memory write enable, address, write data.
REQ-010 SHALL have port mem_rd  input  32  memory read data, valid on the final BUSY cycle.
REQ-011 SHALL have port busy  output  1  high in BUSY and DONE.

Function
REQ-012 SHALL implement the states IDLE, BUSY and DONE.
REQ-013 SHALL, in IDLE with any request high, grant one requester, latch its we/adr/wd, load wait counter with WAIT_STATES, and go to BUSY.
REQ-014 SHALL arbitrate round-robin: if both requests are high, grant the requester not granted last; a single request is granted immediately.
REQ-015 SHALL, in BUSY with counter nonzero, decrement the counter and stay in BUSY.
REQ-016 SHALL, in BUSY with counter zero, pulse mem_we for that cycle if the latched we=1, capture mem_rd into the granted rd register if we=0, and go to DONE.
REQ-017 SHALL, in DONE, assert only the granted ack for exactly one cycle, then go to IDLE.
REQ-018 SHALL give a latency of WAIT_STATES+2 cycles from the grant cycle to the ack; for example, WAIT_STATES=0 gives grant at c0, BUSY at c1, ack at c2.
REQ-019 SHALL drive mem_adr and mem_wd from the latched registers throughout BUSY, and 0 in IDLE.
REQ-020 SHALL keep mem_we low in all cycles except REQ-016.
REQ-021 SHALL hold cpu_rd and dma_rd until that requester's next completed read; writes leave them unchanged.
REQ-022 SHALL, if a request drops during BUSY, still complete the access and ack; the access is not aborted.
REQ-023 SHALL ignore input changes on we/adr/wd after the grant.
REQ-024 SHALL treat a request still high in the IDLE cycle after DONE as a new request (one idle bubble between back-to-back accesses).
REQ-025 SHALL, when a new request arrives during BUSY/DONE, leave it pending and arbitrate it in the next IDLE.

Reset
REQ-026 SHALL, on reset, force state=IDLE, counter=0, last-grant=DMA (so the CPU wins the first tie), and all outputs (including cpu_rd/dma_rd) to 0.
REQ-027 SHALL, on reset asserted mid-access, abandon the access: no ack, no mem_we pulse after reset assertion.

Structure
REQ-028 SHALL place the state encoding (IDLE=0, BUSY=1, DONE=2, 2 bits) and the requester-ID constants (CPU=0, DMA=1) in shared package arb_pkg.
REQ-029 SHALL implement the wait counter as sub-module ws_counter (3-bit, load/decrement/zero flag).
REQ-030 SHALL register all outputs except mem_we; mem_we is decoded from state, counter and latched we.

Verification
REQ-031 SHALL cover: WAIT_STATES=1, CPU read adr 0x00000010 with mem_rd=0xDEADBEEF -> cpu_ack at cycle 3 after grant, cpu_rd=0xDEADBEEF, mem_we never high.
REQ-032 SHALL cover: DMA write adr 0x20, wd 0x12345678 -> exactly one mem_we pulse with mem_adr=0x20, mem_wd=0x12345678; dma_ack next cycle; cpu_ack stays 0.
REQ-033 SHALL cover: both requesters held high from reset for 4 accesses -> grant order CPU, DMA, CPU, DMA, with one IDLE cycle between accesses.
REQ-034 SHALL cover: cpu_req dropped and cpu_adr changed to 0x44 one cycle after grant at 0x40 -> access completes at 0x40, cpu_ack still pulses.
REQ-035 SHALL cover: reset asserted during BUSY of a write -> no mem_we and no ack thereafter; state IDLE; next request is served normally.
REQ-036 SHALL cover: WAIT_STATES=0 -> ack two cycles after grant; no protocol violations flagged by assertions on ack exclusivity (cpu_ack and dma_ack never high together).
